// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues word reads, loads the instruction register,
// and tracks redirects that arrive while a read is still outstanding.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  output logic        ir_load,
  output logic [31:0] ir_in,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  logic [XLEN-1:0] redirect_pc_al;

  assign redirect_pc_al = redirect_pc & ALIGN_MASK;

  // State register; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      pc_q          <= RESET_PC;
      pending_pc_q  <= RESET_PC;
      kill_q        <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_q          <= pc_d;
      pending_pc_q  <= pending_pc_d;
      kill_q        <= kill_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pc_d          = pc_q;
    pending_pc_d  = pending_pc_q;
    kill_d        = kill_q;
    fetch_count_d = fetch_count_q;
    imem_read     = 1'b0;
    ir_load       = 1'b0;
    instr_valid   = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        imem_read = 1'b1;
        if (imem_resp) begin
          if (kill_q || redirect) begin
            // Stale response: drop it and refetch from the newest target.
            kill_d     = 1'b0;
            fetch_pc_d = redirect ? redirect_pc_al : pending_pc_q;
          end else begin
            ir_load = rst_n;
            pc_d    = fetch_pc_q;
            state_d = VALID;
          end
        end else if (redirect) begin
          // Read cannot be aborted; remember where to go once it returns.
          kill_d       = 1'b1;
          pending_pc_d = redirect_pc_al;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (dec_ready) begin
          fetch_count_d = fetch_count_q + XLEN'(1);
        end
        if (redirect) begin
          fetch_pc_d = redirect_pc_al;
          state_d    = REQ;
        end else if (dec_ready) begin
          fetch_pc_d = pc_q + XLEN'(4);
          state_d    = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_address = fetch_pc_q;
  assign ir_in        = imem_rdata;
  assign pc           = pc_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h6000_0000, first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 imem_read  output  1  instruction memory read request.
REQ-005 imem_address  output  32  fetch address; word-aligned.
REQ-006 imem_resp  input  1  memory response valid; completes the outstanding read.
REQ-007 imem_rdata  input  32  instruction word; valid when imem_resp=1.
REQ-008 ir_load  output  1  load strobe to the instruction register.
REQ-009 ir_in  output  32  data to the instruction register; equals imem_rdata combinationally.
REQ-010 pc  output  32  address of the instruction currently held in the instruction register.
REQ-011 instr_valid  output  1  instruction register holds an instruction not yet consumed.
REQ-012 dec_ready  input  1  decode accepts the held instruction this cycle.
REQ-013 redirect  input  1  control-flow change; discard the in-flight or held instruction.
REQ-014 redirect_pc  input  32  new fetch address; valid when redirect=1.
REQ-015 fetch_count  output  32  number of instructions accepted by decode.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, REQ, VALID.
REQ-017 IDLE: all request outputs 0; next state REQ, unconditionally.
REQ-018 REQ: imem_read=1, imem_address=fetch_pc; both stable until imem_resp=1.
REQ-019 REQ with imem_resp=1, kill=0, redirect=0: ir_load=1 same cycle; pc<=fetch_pc; next state VALID.
REQ-020 VALID: instr_valid=1, imem_read=0; stay until dec_ready=1 or redirect=1.
REQ-021 VALID with dec_ready=1, redirect=0: fetch_count+1; fetch_pc<=pc+4; next state REQ.
REQ-022 VALID with redirect=1: fetch_pc<=redirect_pc; next state REQ; instr_valid drops next cycle.
REQ-023 VALID with dec_ready=1 and redirect=1 in the same cycle: fetch_count+1, and fetch_pc<=redirect_pc; redirect target wins over pc+4.
REQ-024 REQ with redirect=1 and imem_resp=0: the read SHALL NOT be aborted; the address stays fixed; set kill=1; store redirect_pc as pending target.
REQ-025 REQ with imem_resp=1 and (kill=1 or redirect=1): ir_load=0; response discarded; kill<=0.
REQ-026 That discarded response SHALL set fetch_pc to the latest redirect target; a redirect in the response cycle overrides the pending one.
REQ-027 That discarded response SHALL return the FSM to REQ, with a new read issued next cycle.
REQ-028 A redirect repeated while kill=1 SHALL overwrite the pending target (latest wins).
REQ-029 The low two bits of redirect_pc SHALL be forced to 2'b00 before use.
REQ-030 pc+4 and fetch_count SHALL wrap modulo 2^32 without flagging.
REQ-031 Minimum latency: response in the first REQ cycle gives ir_load that cycle and instr_valid the next cycle.
REQ-032 Maximum throughput: one instruction per 2 cycles.
REQ-033 ir_load SHALL never be asserted outside REQ.
REQ-034 ir_load SHALL be asserted at most once per memory response.

Reset
REQ-035 While rst_n=0 at a rising edge, the block SHALL enter state IDLE.
REQ-036 That reset SHALL set fetch_pc=pc=RESET_PC, kill=0, and fetch_count=0.
REQ-037 In the cycle after reset, imem_read, ir_load and instr_valid SHALL be 0.
REQ-038 Reset SHALL take priority over redirect, dec_ready and imem_resp.
REQ-039 A response arriving after reset for a pre-reset read SHALL be ignored unless the FSM is in REQ.

Verification
REQ-040 Reset release, memory replies after 3 cycles with 32'h0000_0013, dec_ready=1: imem_address=32'h6000_0000 during the wait; ir_load on the reply cycle; pc=32'h6000_0000; next fetch at 32'h6000_0004; fetch_count=1.
REQ-041 dec_ready=0 for 5 cycles in VALID: instr_valid held; imem_read=0; pc unchanged; no count change.
REQ-042 Redirect to 32'h6000_0103 in REQ, reply 2 cycles later: no ir_load; next address 32'h6000_0100.
REQ-043 Two redirects (32'h100 then 32'h200) during one outstanding read: refetch at 32'h200.
REQ-044 Redirect to 32'h6000_0040 with dec_ready=1 in VALID: fetch_count increments; next address 32'h6000_0040.
REQ-045 rst_n=0 mid-REQ while imem_resp=1: no ir_load; state IDLE; fetch_count=0; fetch restarts at RESET_PC.
